// File: rtl/ber_checker_pkg.sv
// Shared types and constants for the BER checker: FSM states, PRBS9 taps and branch seeds.
// Used by ber_checker (optional loss-of-sync build: define BER_LOS_EN) and prbs9.
package ber_checker_pkg;

    typedef enum logic {
        ALIGN  = 1'b0,
        LOCKED = 1'b1
    } ber_state_e;

    localparam int PRBS9_TAP_HI = 8;
    localparam int PRBS9_TAP_LO = 4;

    localparam logic [8:0] SEED_I = 9'h1AA;
    localparam logic [8:0] SEED_Q = 9'h1FE;

    // x^9 + x^5 + 1, shifting towards the MSB, which is the output bit.
    function automatic logic [8:0] prbs9_next(input logic [8:0] r);
        return {r[7:0], r[PRBS9_TAP_HI] ^ r[PRBS9_TAP_LO]};
    endfunction

endpackage

// File: rtl/ber_checker_prbs9.sv
// PRBS9 generator (x^9+x^5+1); advances one step on each clock with i_ctrl high.
// The current output bit is the register MSB.
module prbs9
    import ber_checker_pkg::*;
#(
    parameter logic [8:0] SEED = SEED_I
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_ctrl,
    output logic o_bit
);

    logic [8:0] lfsr_q;
    logic [8:0] lfsr_d;

    always_comb begin
        lfsr_d = i_ctrl ? prbs9_next(lfsr_q) : lfsr_q;
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples values from before the edge regardless of block ordering.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_bit = lfsr_q[8];

endmodule

// File: rtl/ber_checker.sv
// Per-branch BER checker: decimate, slice, align a local PRBS9 by slipping, count bits/errors.
// Define BER_LOS_EN to drop lock when a locked window sees more than LOS_THR errors.
module ber_checker
    import ber_checker_pkg::*;
#(
    parameter int         NBT_IN    = 8,
    parameter int         OVERSAMP  = 4,
    parameter logic [8:0] SEED      = SEED_I,
    parameter int         ALIGN_WIN = 511,
    parameter int         ALIGN_THR = 0,
    parameter int         LOS_THR   = 64,
    parameter int         NB_CNT    = 64
) (
    input  logic                          clk,
    input  logic                          i_reset,
    input  logic signed [NBT_IN-1:0]      i_sample,
    input  logic                          i_enable,
    input  logic [$clog2(OVERSAMP)-1:0]   i_phase_cnt,
    input  logic [$clog2(OVERSAMP)-1:0]   i_phase_sel,
    output logic                          o_locked,
    output logic [NB_CNT-1:0]             o_bit_count,
    output logic [NB_CNT-1:0]             o_err_count,
    output logic [8:0]                    o_slip_count
);

    localparam int             WCW         = $clog2(ALIGN_WIN + 1);
    localparam logic [WCW-1:0] WIN_LAST    = WCW'(ALIGN_WIN - 1);
    localparam logic [WCW-1:0] ALIGN_THR_W = WCW'(ALIGN_THR);
    localparam logic [8:0]     SLIP_WRAP   = 9'd510;

    ber_state_e        state_q, state_d;
    logic              stb_q;
    logic              rx_bit_q;
    logic [WCW-1:0]    win_cnt_q, win_cnt_d;
    logic [WCW-1:0]    win_err_q, win_err_d;
    logic [8:0]        slip_cnt_q, slip_cnt_d;
    logic [NB_CNT-1:0] bit_cnt_q, bit_cnt_d;
    logic [NB_CNT-1:0] err_cnt_q, err_cnt_d;

    logic              sym_stb;
    logic              ref_bit;
    logic              err;
    logic              slip;
    logic              win_last;
    logic [WCW-1:0]    win_err_sum;

    assign sym_stb     = i_enable & (i_phase_cnt == i_phase_sel);
    assign err         = rx_bit_q ^ ref_bit;
    assign win_last    = (win_cnt_q == WIN_LAST);
    assign win_err_sum = win_err_q + {{(WCW-1){1'b0}}, err};

    // A slip suppresses one advance, so the reference falls one symbol behind the stream.
    prbs9 #(
        .SEED (SEED)
    ) u_prbs9 (
        .clk     (clk),
        .i_reset (i_reset),
        .i_ctrl  (stb_q & ~slip),
        .o_bit   (ref_bit)
    );

    always_ff @(posedge clk) begin
        if (i_reset) begin
            stb_q    <= 1'b0;
            rx_bit_q <= 1'b0;
        end else begin
            stb_q <= sym_stb;
            if (sym_stb) begin
                rx_bit_q <= i_sample[NBT_IN-1];
            end
        end
    end

    // NOTE: every variable gets its default at the top of the block; any path
    // that skipped an assignment would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        win_err_d  = win_err_q;
        slip_cnt_d = slip_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        err_cnt_d  = err_cnt_q;
        slip       = 1'b0;

        if (stb_q) begin
            case (state_q)
                ALIGN: begin
                    if (win_last) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                        if (win_err_sum <= ALIGN_THR_W) begin
                            state_d = LOCKED;
                        end else begin
                            slip       = 1'b1;
                            slip_cnt_d = (slip_cnt_q == SLIP_WRAP) ? 9'd0 : slip_cnt_q + 9'd1;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        win_err_d = win_err_sum;
                    end
                end
                LOCKED: begin
                    // Both counters stop together so the error ratio stays meaningful.
                    if (bit_cnt_q != {NB_CNT{1'b1}}) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        err_cnt_d = err_cnt_q + {{(NB_CNT-1){1'b0}}, err};
                    end
`ifdef BER_LOS_EN
                    if (win_last) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                        if (win_err_sum > WCW'(LOS_THR)) begin
                            state_d    = ALIGN;
                            slip_cnt_d = 9'd0;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        win_err_d = win_err_sum;
                    end
`endif
                end
                default: state_d = ALIGN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q    <= ALIGN;
            win_cnt_q  <= '0;
            win_err_q  <= '0;
            slip_cnt_q <= '0;
            bit_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            win_err_q  <= win_err_d;
            slip_cnt_q <= slip_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_locked     = (state_q == LOCKED);
    assign o_bit_count  = bit_cnt_q;
    assign o_err_count  = err_cnt_q;
    assign o_slip_count = slip_cnt_q;

    // Only the sign bit feeds the slicer.
    logic unused_sample;
    assign unused_sample = ^i_sample[NBT_IN-2:0];
`ifndef BER_LOS_EN
    logic unused_los;
    assign unused_los = (LOS_THR != 0);
`endif

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker: lock, counting, decimation phase, enable, loss of sync,
// slip search, counter saturation (narrow second instance) and reset.
module tb_ber_checker;
    import ber_checker_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] sample;
    logic              enable;
    logic [1:0]        phase_cnt;
    logic [1:0]        phase_sel;

    logic              locked, sat_locked;
    logic [63:0]       bit_count, err_count;
    logic [2:0]        sat_bits, sat_errs;
    logic [8:0]        slip_count, sat_slips;

    int total = 0;
    int bad   = 0;

    logic [8:0]  tx_a;
    logic [8:0]  tx_b;
    logic [63:0] exp_bits;
    logic [63:0] exp_err;

    always #5 clk = ~clk;

    ber_checker dut (
        .clk          (clk),
        .i_reset      (rst),
        .i_sample     (sample),
        .i_enable     (enable),
        .i_phase_cnt  (phase_cnt),
        .i_phase_sel  (phase_sel),
        .o_locked     (locked),
        .o_bit_count  (bit_count),
        .o_err_count  (err_count),
        .o_slip_count (slip_count)
    );

    ber_checker #(
        .NB_CNT (3)
    ) u_sat (
        .clk          (clk),
        .i_reset      (rst),
        .i_sample     (sample),
        .i_enable     (enable),
        .i_phase_cnt  (phase_cnt),
        .i_phase_sel  (phase_sel),
        .o_locked     (sat_locked),
        .o_bit_count  (sat_bits),
        .o_err_count  (sat_errs),
        .o_slip_count (sat_slips)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // One symbol: the wanted bit sits at the selected phase, its inverse at the others.
    task automatic send_sym(input logic b);
        for (int p = 0; p < 4; p++) begin
            logic v;
            phase_cnt = 2'(p);
            v         = (2'(p) == phase_sel) ? b : ~b;
            sample    = v ? -8'sd64 : 8'sd64;
            @(posedge clk);
            #1;
        end
    endtask

    // Stream from tx_a (or tx_b), inverting every inv_every-th bit; when counting,
    // the expected locked counters follow against the tx_a reference.
    task automatic send_stream(input int n, input int inv_every, input bit use_b, input bit counting);
        for (int i = 0; i < n; i++) begin
            logic r, b;
            r = tx_a[8];
            b = use_b ? tx_b[8] : r;
            if (inv_every != 0 && ((i + 1) % inv_every) == 0) b = ~b;
            if (counting) begin
                exp_bits++;
                if (b != r) exp_err++;
            end
            send_sym(b);
            tx_a = prbs9_next(tx_a);
            tx_b = prbs9_next(tx_b);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        phase_sel = 2'd0;
        phase_cnt = 2'd3;
        sample    = 8'sd0;
        tx_a      = SEED_I;
        tx_b      = SEED_Q;
        exp_bits  = 64'd0;
        exp_err   = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_locked", {63'd0, locked}, 64'd0);
        check("rst_bits", bit_count, 64'd0);
        check("rst_errs", err_count, 64'd0);
        check("rst_slips", {55'd0, slip_count}, 64'd0);

        // Aligned stream: lock exactly at the 511th symbol, no slips.
        send_stream(510, 0, 0, 0);
        check("pre_lock", {63'd0, locked}, 64'd0);
        send_stream(1, 0, 0, 0);
        check("lock_aligned", {63'd0, locked}, 64'd1);
        check("lock_slips", {55'd0, slip_count}, 64'd0);
        check("lock_bits", bit_count, 64'd0);

        send_stream(2000, 0, 0, 1);
        check("bits_2000", bit_count, 64'd2000);
        check("errs_2000", err_count, 64'd0);
        check("sat_bits_held", {61'd0, sat_bits}, 64'd7);
        check("sat_errs_2000", {61'd0, sat_errs}, 64'd0);

        // Decimation moves to phase 2; other phases carry the inverted bit.
        phase_sel = 2'd2;
        send_stream(100, 0, 0, 1);
        check("phase2_bits", bit_count, 64'd2100);
        check("phase2_errs", err_count, 64'd0);

        send_stream(1000, 100, 0, 1);
        check("inj_bits", bit_count, 64'd3100);
        check("inj_errs", err_count, 64'd10);
        check("sat_errs_frozen", {61'd0, sat_errs}, 64'd0);

        enable = 1'b0;
        for (int c = 0; c < 200; c++) begin
            phase_cnt = 2'(c);
            sample    = 8'($urandom);
            @(posedge clk);
            #1;
        end
        check("dis_bits", bit_count, 64'd3100);
        check("dis_errs", err_count, 64'd10);
        enable = 1'b1;
        send_stream(100, 0, 0, 1);
        check("reen_locked", {63'd0, locked}, 64'd1);
        check("reen_bits", bit_count, 64'd3200);
        check("reen_errs", err_count, 64'd10);

        // 3200 locked strobes = 6 windows + 134, so the window closes 377 symbols from now.
        tx_b = SEED_Q;
`ifdef BER_LOS_EN
        send_stream(376, 0, 1, 1);
        check("los_before_end", {63'd0, locked}, 64'd1);
        send_stream(1, 0, 1, 1);
        check("los_dropped", {63'd0, locked}, 64'd0);
        check("los_slips", {55'd0, slip_count}, 64'd0);
        check("los_bits", bit_count, 64'd3577);
        check("los_errs", err_count, exp_err);
        send_stream(50, 0, 1, 0);
        check("los_bits_held", bit_count, 64'd3577);
        check("los_errs_held", err_count, exp_err);
`else
        send_stream(377, 0, 1, 1);
        check("sticky_locked", {63'd0, locked}, 64'd1);
        send_stream(50, 0, 1, 1);
        check("sticky_bits", bit_count, 64'd3627);
        check("sticky_errs", err_count, exp_err);
`endif

        // Stream delayed by 3 symbols: three failed windows, lock with three slips.
        pulse_reset();
        tx_a = SEED_I;
        repeat (3) send_sym(1'b0);
        send_stream(2040, 0, 0, 0);
        check("off_pre_lock", {63'd0, locked}, 64'd0);
        check("off_pre_slips", {55'd0, slip_count}, 64'd3);
        send_stream(1, 0, 0, 0);
        check("off_locked", {63'd0, locked}, 64'd1);
        check("off_slips", {55'd0, slip_count}, 64'd3);
        check("off_bits", bit_count, 64'd0);

        // Narrow instance saturates its bit counter at 7; the error counter stops with it.
        send_stream(6, 2, 0, 0);
        check("sat_pre_bits", {61'd0, sat_bits}, 64'd6);
        check("sat_pre_errs", {61'd0, sat_errs}, 64'd3);
        send_stream(3, 1, 0, 0);
        check("main_bits_9", bit_count, 64'd9);
        check("main_errs_6", err_count, 64'd6);
        check("sat_bits_top", {61'd0, sat_bits}, 64'd7);
        check("sat_errs_stop", {61'd0, sat_errs}, 64'd4);

        pulse_reset();
        check("mid_rst_locked", {63'd0, locked}, 64'd0);
        check("mid_rst_bits", bit_count, 64'd0);
        check("mid_rst_errs", err_count, 64'd0);
        check("mid_rst_slips", {55'd0, slip_count}, 64'd0);
        check("mid_rst_sat_bits", {61'd0, sat_bits}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
